// File: rtl/mem_cmd_sequencer_pkg.sv
// Shared opcodes, header field positions and FSM state encoding for the memory command sequencer.
package mem_cmd_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int HDR_OP_LSB  = 6;
    localparam int HDR_LEN_LSB = 0;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR      = 3'd1;
    localparam logic [2:0] S_ADDR     = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_WRITE    = 3'd4;
    localparam logic [2:0] S_RD_ISSUE = 3'd5;
    localparam logic [2:0] S_RD_WAIT  = 3'd6;
    localparam logic [2:0] S_RSP      = 3'd7;

    function automatic logic [1:0] hdr_op(input logic [7:0] hdr);
        return hdr[HDR_OP_LSB +: 2];
    endfunction

    function automatic logic [3:0] hdr_len_m1(input logic [7:0] hdr);
        return hdr[HDR_LEN_LSB +: 4];
    endfunction

endpackage

// File: rtl/mem_cmd_sequencer_if.sv
// FIFO read port, BRAM port and read-response port of the sequencer, bundled as one interface.
interface mem_cmd_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              fifo_empty;
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_data;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic [DATA_W-1:0] bram_out;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              busy;
    logic              err_cmd;

    modport master (
        input  fifo_empty, fifo_data, bram_out, rsp_ready,
        output fifo_r_en, bram_addr, bram_data, bram_we, rsp_data, rsp_valid, busy, err_cmd
    );

    modport slave (
        output fifo_empty, fifo_data, bram_out, rsp_ready,
        input  fifo_r_en, bram_addr, bram_data, bram_we, rsp_data, rsp_valid, busy, err_cmd
    );
endinterface

// File: rtl/mem_cmd_sequencer_lat_counter.sv
// Down-counter timing a fixed read latency: done is high exactly lat cycles after start.
// Latency set by the lat input (1..2^W-1); no backpressure, a new start reloads the count.
module lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] lat,
    output logic         active,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= lat;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign active = (cnt != '0);
    assign done   = (cnt == W'(1));
endmodule

// File: rtl/mem_cmd_sequencer.sv
// Pops command frames from the FIFO read port, drives the BRAM port and returns read data.
// Write beat FIFO_RD_LAT+2 cycles, read beat BRAM_RD_LAT+2 plus any rsp_ready stall; stalls hold the response.
module mem_cmd_sequencer #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int FIFO_RD_LAT = 1,
    parameter int BRAM_RD_LAT = 1
) (
    input  logic                 clk_mem,
    input  logic                 reset,
    mem_cmd_sequencer_if.master  bus
);
    import mem_cmd_pkg::*;

    logic [2:0]        state;
    logic [1:0]        op;
    logic [3:0]        beats_left;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] bram_addr_q;
    logic [DATA_W-1:0] bram_data_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_valid_q;
    logic              err_q;

    logic              pop_state;
    logic              pop;
    logic              capture;
    logic              last;
    logic              wait_start;
    logic [1:0]        wait_lat;
    logic              wait_active;
    logic              wait_done;
    logic [DATA_W-1:0] word;

    assign word      = bus.fifo_data;
    assign last      = (beats_left == 4'd0);
    assign pop_state = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
    // One pop in flight: a pop state only strobes again once the previous word is captured.
    assign pop       = pop_state && !wait_active && !bus.fifo_empty && !reset;
    assign capture   = wait_done && ((state == S_HDR) || (state == S_ADDR) || (state == S_DATA));

    assign wait_start = pop || (state == S_RD_ISSUE);
    assign wait_lat   = (state == S_RD_ISSUE) ? 2'(BRAM_RD_LAT) : 2'(FIFO_RD_LAT);

    lat_counter #(.W(2)) u_lat (
        .clk    (clk_mem),
        .reset  (reset),
        .start  (wait_start),
        .lat    (wait_lat),
        .active (wait_active),
        .done   (wait_done)
    );

    always_ff @(posedge clk_mem) begin
        if (reset) begin
            state       <= S_IDLE;
            op          <= OP_NOP;
            beats_left  <= '0;
            addr        <= '0;
            bram_addr_q <= '0;
            bram_data_q <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) state <= S_HDR;
                end
                S_HDR: begin
                    if (capture) begin
                        op         <= hdr_op(word[7:0]);
                        beats_left <= hdr_len_m1(word[7:0]);
                        case (hdr_op(word[7:0]))
                            OP_WRITE, OP_READ: state <= S_ADDR;
                            OP_RSVD: begin
                                err_q <= 1'b1;
                                state <= S_IDLE;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (capture) begin
                        addr <= word[ADDR_W-1:0];
                        if (op == OP_READ) begin
                            bram_addr_q <= word[ADDR_W-1:0];
                            state       <= S_RD_ISSUE;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (capture) begin
                        bram_addr_q <= addr;
                        bram_data_q <= word;
                        state       <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    addr       <= addr + 1'b1;
                    beats_left <= beats_left - 1'b1;
                    state      <= last ? S_IDLE : S_DATA;
                end
                S_RD_ISSUE: begin
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (wait_done) begin
                        rsp_data_q  <= bus.bram_out;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        addr        <= addr + 1'b1;
                        beats_left  <= beats_left - 1'b1;
                        // bram_addr keeps the last issued address once the frame is done.
                        if (!last) bram_addr_q <= addr + 1'b1;
                        state <= last ? S_IDLE : S_RD_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.fifo_r_en = pop;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_data = bram_data_q;
    assign bus.bram_we   = (state == S_WRITE) && !reset;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.err_cmd   = err_q;
endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Bench for mem_cmd_sequencer: FIFO/BRAM models around the DUT, frame-level reference model.
module tb_mem_cmd_sequencer;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int FRL = 2;
    localparam int BRL = 3;
    localparam int TMO = 8000;

    logic clk_mem = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_mem = ~clk_mem;

    mem_cmd_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_cmd_sequencer #(
        .DATA_W(DW), .ADDR_W(AW), .FIFO_RD_LAT(FRL), .BRAM_RD_LAT(BRL)
    ) dut (
        .clk_mem (clk_mem),
        .reset   (reset),
        .bus     (bus)
    );

    logic [7:0] fmem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] fpipe [0:FRL-1] = '{default: 8'h00};
    logic [7:0] bmem  [0:255]   = '{default: 8'h00};
    logic [7:0] bpipe [0:BRL-1] = '{default: 8'h00};

    logic gap = 1'b0, gap_en = 1'b0, rdy = 1'b1, rdy_rand = 1'b0, rdy_force = 1'b1;

    logic [7:0] wlog_a [0:1023];
    logic [7:0] wlog_d [0:1023];
    logic [7:0] rlog   [0:1023];
    int         wlog_t [0:1023];
    int         rlog_t [0:1023];
    int         wn = 0, rn = 0, err_n = 0, pop_viol = 0, stall_viol = 0, cyc = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_dat = 8'h00, stall_addr = 8'h00;

    assign bus.fifo_empty = (wr_ptr == rd_ptr) || gap;
    assign bus.fifo_data  = fpipe[FRL-1];
    assign bus.bram_out   = bpipe[BRL-1];
    assign bus.rsp_ready  = rdy;

    // FIFO, BRAM and protocol monitor
    always @(posedge clk_mem) begin
        cyc <= cyc + 1;
        if (bus.fifo_r_en) begin
            if (bus.fifo_empty) pop_viol <= pop_viol + 1;
            if (rd_ptr != wr_ptr) begin
                fpipe[0] <= fmem[rd_ptr % 1024];
                rd_ptr   <= rd_ptr + 1;
            end
        end
        for (int i = 1; i < FRL; i++) fpipe[i] <= fpipe[i-1];
        if (bus.bram_we) begin
            bmem[bus.bram_addr] <= bus.bram_data;
            if (wn < 1024) begin
                wlog_a[wn] <= bus.bram_addr;
                wlog_d[wn] <= bus.bram_data;
                wlog_t[wn] <= cyc;
            end
            wn <= wn + 1;
        end
        bpipe[0] <= bmem[bus.bram_addr];
        for (int i = 1; i < BRL; i++) bpipe[i] <= bpipe[i-1];
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (rn < 1024) begin
                rlog[rn]   <= bus.rsp_data;
                rlog_t[rn] <= cyc;
            end
            rn <= rn + 1;
        end
        if (bus.err_cmd) err_n <= err_n + 1;
        if (stall_prev && (!bus.rsp_valid || bus.rsp_data != stall_dat || bus.bram_addr != stall_addr))
            stall_viol <= stall_viol + 1;
        stall_prev <= bus.rsp_valid && !bus.rsp_ready;
        stall_dat  <= bus.rsp_data;
        stall_addr <= bus.bram_addr;
    end

    initial forever begin
        @(negedge clk_mem);
        gap = gap_en && ($urandom_range(0, 2) == 0);
        rdy = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_force;
    end

    // Frame-level reference model
    logic [7:0] frm [$];
    logic [7:0] exp_wa [$];
    logic [7:0] exp_wd [$];
    logic [7:0] exp_rd [$];
    logic [7:0] ref_mem [0:255] = '{default: 8'h00};
    int exp_err = 0, wchk = 0, rchk = 0, checks = 0, errors = 0, n = 0, base = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] outs();
        return {3'b000, bus.fifo_r_en, bus.bram_addr, bus.bram_data, bus.bram_we,
                bus.rsp_data, bus.rsp_valid, bus.busy, bus.err_cmd};
    endfunction

    task automatic push_frame(input bit model);
        logic [1:0] op;
        logic [7:0] a;
        int beats;
        foreach (frm[i]) begin
            fmem[wr_ptr % 1024] = frm[i];
            wr_ptr++;
        end
        if (model) begin
            op    = frm[0][7:6];
            beats = int'(frm[0][3:0]) + 1;
            for (int i = 0; i < beats; i++) begin
                if (op == 2'b01) begin
                    a = frm[1] + 8'(i);
                    ref_mem[a] = frm[2+i];
                    exp_wa.push_back(a);
                    exp_wd.push_back(frm[2+i]);
                end else if (op == 2'b10) begin
                    a = frm[1] + 8'(i);
                    exp_rd.push_back(ref_mem[a]);
                end
            end
            if (op == 2'b11) exp_err++;
        end
    endtask

    task automatic compare_logs(input string tag);
        chk({tag, "_wr_count"}, wn, exp_wa.size());
        chk({tag, "_rd_count"}, rn, exp_rd.size());
        chk({tag, "_err_count"}, err_n, exp_err);
        while (wchk < wn && wchk < exp_wa.size()) begin
            chk({tag, "_wr_addr"}, wlog_a[wchk], exp_wa[wchk]);
            chk({tag, "_wr_data"}, wlog_d[wchk], exp_wd[wchk]);
            wchk++;
        end
        while (rchk < rn && rchk < exp_rd.size()) begin
            chk({tag, "_rsp_data"}, rlog[rchk], exp_rd[rchk]);
            rchk++;
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((rd_ptr != wr_ptr || bus.busy || wn < exp_wa.size() || rn < exp_rd.size()) && k < TMO) begin
            @(negedge clk_mem);
            k++;
        end
        repeat (4) @(negedge clk_mem);
        chk({tag, "_done_in_time"}, k < TMO, 1'b1);
        compare_logs(tag);
    endtask

    initial begin
        logic [1:0] rop;
        int r;
        repeat (3) @(negedge clk_mem);
        chk("reset_outputs", outs(), 32'h0);
        reset = 1'b0;
        @(negedge clk_mem);

        base = wn;
        frm = '{8'h42, 8'h10, 8'hAA, 8'hBB, 8'hCC};
        push_frame(1'b1);
        drain("write");
        chk("write_beat_gap0", wlog_t[base+1] - wlog_t[base], FRL + 2);
        chk("write_beat_gap1", wlog_t[base+2] - wlog_t[base+1], FRL + 2);
        chk("write_no_extra_pop", pop_viol, 0);
        chk("idle_hold_addr", bus.bram_addr, 8'h12);
        chk("idle_hold_data", bus.bram_data, 8'hCC);

        frm = '{8'h41, 8'h20, 8'h5A, 8'hA5};
        push_frame(1'b1);
        drain("preload");
        rdy_force = 1'b0;
        @(negedge clk_mem);
        frm = '{8'h81, 8'h20};
        push_frame(1'b1);
        n = 0;
        while (!bus.rsp_valid && n < TMO) begin
            @(negedge clk_mem);
            n++;
        end
        chk("stall_rsp_seen", bus.rsp_valid, 1'b1);
        repeat (4) begin
            chk("stall_hold_data", bus.rsp_data, 8'h5A);
            @(negedge clk_mem);
        end
        rdy_force = 1'b1;
        drain("read_stall");
        chk("stall_stable", stall_viol, 0);

        frm = '{8'h41, 8'hFF, 8'h11, 8'h22};
        push_frame(1'b1);
        drain("wrap");

        base = rn;
        frm = '{8'h00};
        push_frame(1'b1);
        frm = '{8'hC3};
        push_frame(1'b1);
        frm = '{8'h81, 8'hFF};
        push_frame(1'b1);
        drain("nop_rsvd");
        chk("read_beat_gap", rlog_t[base+1] - rlog_t[base], BRL + 2);

        frm = '{8'h42, 8'h30, 8'h77};
        push_frame(1'b0);
        exp_wa.push_back(8'h30);
        exp_wd.push_back(8'h77);
        ref_mem[8'h30] = 8'h77;
        n = 0;
        while (wn < exp_wa.size() && n < TMO) begin
            @(negedge clk_mem);
            n++;
        end
        repeat (3) @(negedge clk_mem);
        chk("midframe_busy", bus.busy, 1'b1);
        reset = 1'b1;
        repeat (3) @(negedge clk_mem);
        chk("reset_mid_outputs", outs(), 32'h0);
        reset = 1'b0;
        compare_logs("reset_mid");
        frm = '{8'h80, 8'h30};
        push_frame(1'b1);
        frm = '{8'h40, 8'h31, 8'h99};
        push_frame(1'b1);
        drain("after_reset");

        gap_en   = 1'b1;
        rdy_rand = 1'b1;
        for (int f = 0; f < 24; f++) begin
            r = $urandom_range(0, 9);
            rop = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            frm.delete();
            frm.push_back({rop, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))});
            if (rop == 2'b01 || rop == 2'b10) frm.push_back(8'($urandom_range(0, 255)));
            if (rop == 2'b01) begin
                for (int b = 0; b <= int'(frm[0][3:0]); b++) frm.push_back(8'($urandom_range(0, 255)));
            end
            push_frame(1'b1);
        end
        drain("random");
        chk("random_pop_rule", pop_viol, 0);
        chk("random_rsp_stable", stall_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
